// File: rtl/codeword_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : codeword_pkg
// Brief   : Legal wxyz codewords, serializer state encoding and symbol map.
// Revision: 1.0 - initial release
// ============================================================================
package codeword_pkg;

    localparam logic [3:0] CW0 = 4'b0011;
    localparam logic [3:0] CW1 = 4'b0100;
    localparam logic [3:0] CW2 = 4'b1000;
    localparam logic [3:0] CW3 = 4'b1111;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    function automatic logic [3:0] cw_of(input logic [1:0] sym);
        logic [3:0] cw;
        case (sym)
            2'd0:    cw = CW0;
            2'd1:    cw = CW1;
            2'd2:    cw = CW2;
            default: cw = CW3;
        endcase
        return cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/codeword_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : codeword_serializer_if
// Brief   : Symbol input and serial output handshakes of the codeword link.
// Revision: 1.0 - initial release
// ============================================================================
interface codeword_serializer_if;

    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;

    modport master (
        output sym, sym_valid, out_ready,
        input  sym_ready, out_bit, out_valid, out_first, out_last
    );

    modport slave (
        input  sym, sym_valid, out_ready,
        output sym_ready, out_bit, out_valid, out_first, out_last
    );

endinterface
`default_nettype wire

// File: rtl/codeword_serializer_rom.sv
`default_nettype none
// ============================================================================
// Module  : codeword_rom
// Brief   : Combinational symbol to wxyz codeword lookup.
// Revision: 1.0 - initial release
// ============================================================================
module codeword_rom
    import codeword_pkg::*;
(
    input  logic [1:0] i_sym,
    output logic [3:0] o_cw
);

    assign o_cw = cw_of(i_sym);

endmodule
`default_nettype wire

// File: rtl/codeword_serializer.sv
`default_nettype none
// ============================================================================
// Module  : codeword_serializer
// Brief   : One-entry buffered symbol to serial wxyz codeword transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module codeword_serializer
    import codeword_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    codeword_serializer_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD =
        (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;

    logic [1:0]         r_state;
    logic [1:0]         r_buf;
    logic               r_buf_full;
    logic [3:0]         r_shreg;
    logic [1:0]         r_bit_idx;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic [3:0] w_cw;
    logic       w_shift;
    logic       w_last;
    logic       w_frame_done;
    logic       w_accept;
    logic       w_load;

    codeword_rom u_rom (
        .i_sym (r_buf),
        .o_cw  (w_cw)
    );

    assign w_shift      = (r_state == SHIFT);
    assign w_last       = (r_bit_idx == 2'd3);
    assign w_frame_done = w_shift & bus.out_ready & w_last;
    assign w_accept     = bus.sym_valid & ~r_buf_full;

    // A buffered word loads from IDLE, at the end of the gap, or straight
    // after a last bit when no gap is configured, so frames can abut.
    assign w_load = r_buf_full &
                    ((r_state == IDLE) |
                     (w_frame_done & (GAP_CYCLES == 0)) |
                     ((r_state == GAP) & (r_gap_cnt == '0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_buf       <= 2'd0;
            r_buf_full  <= 1'b0;
            r_shreg     <= 4'd0;
            r_bit_idx   <= 2'd0;
            r_gap_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_buf      <= bus.sym;
                r_buf_full <= 1'b1;
            end

            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end

            if (w_load) begin
                r_shreg    <= w_cw;
                r_bit_idx  <= 2'd0;
                r_buf_full <= 1'b0;
                r_state    <= SHIFT;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    SHIFT: begin
                        if (bus.out_ready) begin
                            if (!w_last) begin
                                r_shreg   <= {r_shreg[2:0], 1'b0};
                                r_bit_idx <= r_bit_idx + 2'd1;
                            end else if (GAP_CYCLES > 0) begin
                                r_gap_cnt <= c_GAP_LOAD;
                                r_state   <= GAP;
                            end else begin
                                r_state   <= IDLE;
                            end
                        end
                    end
                    GAP: begin
                        if (r_gap_cnt == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sym_ready = ~r_buf_full;
    assign bus.out_valid = w_shift;
    assign bus.out_bit   = w_shift & r_shreg[3];
    assign bus.out_first = w_shift & (r_bit_idx == 2'd0);
    assign bus.out_last  = w_shift & w_last;
    assign busy          = (r_state != IDLE) | r_buf_full;
    assign frame_cnt     = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_codeword_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_codeword_serializer
// Brief   : Scoreboard bench for two serializer configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_codeword_serializer;
    import codeword_pkg::*;

    localparam int GAP1  = 2;
    localparam int CNTW1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    logic [7:0]       fc0;
    logic [CNTW1-1:0] fc1;
    logic             busy0, busy1;

    codeword_serializer_if if0 ();
    codeword_serializer_if if1 ();

    codeword_serializer #(.GAP_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0), .busy(busy0), .frame_cnt(fc0));
    codeword_serializer #(.GAP_CYCLES(GAP1), .CNT_W(CNTW1)) dut1 (
        .clk(clk), .reset(rst1), .bus(if1), .busy(busy1), .frame_cnt(fc1));

    logic mv [2], mb [2], mf [2], ml [2], mr [2], sr [2], bz [2];
    int   fcv [2];
    assign mv[0] = if0.out_valid;  assign mv[1] = if1.out_valid;
    assign mb[0] = if0.out_bit;    assign mb[1] = if1.out_bit;
    assign mf[0] = if0.out_first;  assign mf[1] = if1.out_first;
    assign ml[0] = if0.out_last;   assign ml[1] = if1.out_last;
    assign mr[0] = if0.out_ready;  assign mr[1] = if1.out_ready;
    assign sr[0] = if0.sym_ready;  assign sr[1] = if1.sym_ready;
    assign bz[0] = busy0;          assign bz[1] = busy1;
    assign fcv[0] = {24'd0, fc0};  assign fcv[1] = {30'd0, fc1};

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    // Reference codewords written out independently of the package.
    logic [3:0] ref_cw [4] = '{4'b0011, 4'b0100, 4'b1000, 4'b1111};

    function automatic logic fwxyz(input logic [3:0] v);
        logic w, x, y, z;
        {w, x, y, z} = v;
        return (w & x & y & z) | (!w & !x & y & z) | (!w & x & !y & !z) | (w & !x & !y & !z);
    endfunction

    // Scoreboard: one {bit, first, last} entry per expected serial bit.
    logic [2:0] q0 [$];
    logic [2:0] q1 [$];

    function automatic void qpush(input int i, input logic [2:0] e);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endfunction
    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction
    function automatic logic [2:0] qpop(input int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction
    function automatic void qclear(input int i);
        if (i == 0) q0.delete(); else q1.delete();
    endfunction

    // Monitor state
    int         exp_cnt [2];
    int         zeros   [2];
    logic       track   [2];
    logic       pend    [2];
    logic       pv [2], pr [2], pb [2], pf [2], pl [2];
    logic [3:0] word    [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_cnt[i] = 0; zeros[i] = 0; track[i] = 1'b0; pend[i] = 1'b0;
            pv[i] = 1'b0; pr[i] = 1'b0; pb[i] = 1'b0; pf[i] = 1'b0; pl[i] = 1'b0;
            word[i] = 4'd0;
        end
    end

    task automatic mon(input int i);
        logic       rs;
        logic [2:0] e;
        int         gap_req, cnt_mod;
        rs      = (i == 0) ? rst0 : rst1;
        gap_req = (i == 0) ? 0 : GAP1;
        cnt_mod = (i == 0) ? 256 : (1 << CNTW1);
        if (rs) begin
            qclear(i);
            exp_cnt[i] = 0;
            track[i]   = 1'b0;
            pv[i]      = 1'b0;
            return;
        end
        chk($sformatf("frame_cnt%0d", i), fcv[i], exp_cnt[i] % cnt_mod);
        if (pv[i] && !pr[i]) begin
            chk($sformatf("hold_valid%0d", i), int'(mv[i]), 1);
            chk($sformatf("hold_bits%0d", i), int'({mb[i], mf[i], ml[i]}), int'({pb[i], pf[i], pl[i]}));
        end
        if (!mv[i]) begin
            chk($sformatf("idle_zero%0d", i), int'({mb[i], mf[i], ml[i]}), 0);
            if (track[i]) zeros[i]++;
        end else begin
            if (track[i]) begin
                if (pend[i]) chk($sformatf("gap_exact%0d", i), zeros[i], gap_req);
                else         chk($sformatf("gap_min%0d", i), int'(zeros[i] >= gap_req), 1);
                track[i] = 1'b0;
            end
            if (mr[i]) begin
                if (qsize(i) == 0) begin
                    chk($sformatf("unexpected_bit%0d", i), int'({mb[i], mf[i], ml[i]}), -1);
                end else begin
                    e = qpop(i);
                    chk($sformatf("bit%0d", i), int'({mb[i], mf[i], ml[i]}), int'(e));
                end
                word[i] = {word[i][2:0], mb[i]};
                if (ml[i]) begin
                    exp_cnt[i]++;
                    chk($sformatf("fwxyz%0d", i), int'(fwxyz(word[i])), 1);
                    track[i] = 1'b1;
                    zeros[i] = 0;
                    pend[i]  = (qsize(i) != 0);
                end
            end
        end
        pv[i] = mv[i]; pr[i] = mr[i]; pb[i] = mb[i]; pf[i] = mf[i]; pl[i] = ml[i];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // out_ready per side: 0 = held high, 1 = random, 2 = held low
    int rmode [2] = '{0, 0};
    always @(posedge clk) begin
        #1;
        if0.out_ready = (rmode[0] == 0) ? 1'b1 : (rmode[0] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if1.out_ready = (rmode[1] == 0) ? 1'b1 : (rmode[1] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sym(input int i, input logic [1:0] s, input logic v);
        if (i == 0) begin if0.sym = s; if0.sym_valid = v; end
        else        begin if1.sym = s; if1.sym_valid = v; end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int i, input logic [1:0] s);
        int t = 0;
        set_sym(i, s, 1'b1);
        while (!sr[i]) begin
            cyc(1);
            t++;
            if (t > 300) begin
                chk($sformatf("send%0d_timeout", i), t, 0);
                set_sym(i, s, 1'b0);
                return;
            end
        end
        @(posedge clk);
        for (int k = 3; k >= 0; k--)
            qpush(i, {ref_cw[s][k], 1'(k == 3), 1'(k == 0)});
        #1;
        set_sym(i, 2'd0, 1'b0);
    endtask

    task automatic drain(input int i);
        int t = 0;
        while (qsize(i) != 0 || bz[i]) begin
            cyc(1);
            t++;
            if (t > 1000) begin
                chk($sformatf("drain%0d_timeout", i), t, 0);
                return;
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        if0.sym = 2'd0; if0.sym_valid = 1'b0; if0.out_ready = 1'b1;
        if1.sym = 2'd0; if1.sym_valid = 1'b0; if1.out_ready = 1'b1;
        for (int s = 0; s < 4; s++)
            chk($sformatf("cw_of%0d", s), int'(cw_of(2'(s))), int'(ref_cw[s]));
        cyc(3);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_sym_ready%0d", i), int'(sr[i]), 1);
            chk($sformatf("rst_busy%0d", i), int'(bz[i]), 0);
            chk($sformatf("rst_out_valid%0d", i), int'(mv[i]), 0);
            chk($sformatf("rst_frame_cnt%0d", i), fcv[i], 0);
        end
        cyc(1);

        // Single frame of sym 2
        send(0, 2'd2);
        drain(0);
        chk("single_frame_cnt", fcv[0], 1);
        chk("single_busy", int'(bz[0]), 0);

        // Back-to-back stream
        for (int s = 0; s < 4; s++) send(0, 2'(s));
        drain(0);
        chk("stream_frame_cnt", fcv[0], 5);

        // Receiver stall during bit 2 with a second word buffered
        send(0, 2'd3);
        send(0, 2'd1);
        rmode[0] = 2;
        @(negedge clk);
        chk("stall_sym_ready", int'(sr[0]), 0);
        chk("stall_busy", int'(bz[0]), 1);
        cyc(3);
        rmode[0] = 0;
        drain(0);
        chk("stall_frame_cnt", fcv[0], 7);

        // Reset on bit 3 with the buffer full
        send(0, 2'd0);
        send(0, 2'd1);
        cyc(1);
        rst0 = 1'b1;
        cyc(1);
        rst0 = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(mv[0]), 0);
        chk("abort_frame_cnt", fcv[0], 0);
        chk("abort_sym_ready", int'(sr[0]), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_quiet", int'(mv[0]), 0);
        end
        cyc(1);

        // Randomized traffic with random receiver back-pressure
        rmode[0] = 1;
        for (int n = 0; n < 40; n++) begin
            send(0, 2'($urandom_range(0, 3)));
            cyc($urandom_range(0, 3));
        end
        drain(0);
        rmode[0] = 0;
        chk("rand_frame_cnt", fcv[0], 40);

        // Gap configuration: two frames, then wrap of the 2-bit counter
        send(1, 2'd1);
        send(1, 2'd2);
        drain(1);
        chk("gap_frame_cnt", fcv[1], 2);
        for (int n = 0; n < 3; n++) send(1, 2'($urandom_range(0, 3)));
        drain(1);
        chk("wrap_frame_cnt", fcv[1], 1);
        rmode[1] = 1;
        for (int n = 0; n < 12; n++) begin
            send(1, 2'($urandom_range(0, 3)));
            cyc($urandom_range(0, 2));
        end
        drain(1);
        rmode[1] = 0;
        chk("gap_rand_frame_cnt", fcv[1], 17 % 4);

        cyc(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
